// File: rtl/dual_input_debouncer.sv
// Two-channel input conditioner: 2-flop synchroniser, tick-qualified debounce
// counter and registered rising-edge strobe per channel, all from flops.
module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic rawA,
  input  logic rawB,
  output logic A,
  output logic B,
  output logic riseA,
  output logic riseB
);

  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] rawVec;
  logic [1:0] stableVec;
  logic [1:0] riseVec;

  assign rawVec = {rawB, rawA};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gChannel
      logic       sync1Reg;
      logic       sync2Reg;
      logic       stableReg;
      logic       riseReg;
      logic [7:0] cntReg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sync1Reg  <= 1'b0;
          sync2Reg  <= 1'b0;
          stableReg <= 1'b0;
          riseReg   <= 1'b0;
          cntReg    <= 8'd0;
        end else begin
          sync1Reg <= rawVec[gi];
          sync2Reg <= sync1Reg;
          riseReg  <= 1'b0;
          if (tick) begin
            if (sync2Reg == stableReg) begin
              cntReg <= 8'd0;
            end else if (cntReg == LAST_COUNT) begin
              // Accept the new level; the strobe fires only for a 0->1 acceptance.
              stableReg <= sync2Reg;
              riseReg   <= sync2Reg;
              cntReg    <= 8'd0;
            end else begin
              cntReg <= cntReg + 8'd1;
            end
          end
        end
      end

      assign stableVec[gi] = stableReg;
      assign riseVec[gi]   = riseReg;
    end
  endgenerate

  assign A     = stableVec[0];
  assign B     = stableVec[1];
  assign riseA = riseVec[0];
  assign riseB = riseVec[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Self-checking bench for dual_input_debouncer: directed scenarios with fixed
// edge expectations plus randomized traffic checked against a behavioural model.
module tb_dual_input_debouncer;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b1;
  logic rawA = 1'b0;
  logic rawB = 1'b0;
  logic A, B, riseA, riseB;

  int checks = 0;
  int passed = 0;

  dual_input_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .rawA(rawA), .rawB(rawB),
    .A(A), .B(B), .riseA(riseA), .riseB(riseB)
  );

  always #5 clock = ~clock;

  // Behavioural model: the raw level is seen two clocks late; a level is
  // accepted once N ticks in a row have seen something different from it.
  bit   seenHist[2][$];
  int   runLen[2];
  bit   mLevel[2];
  bit   mRise[2];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        seenHist[c] = {1'b0, 1'b0};
        runLen[c]   = 0;
        mLevel[c]   = 1'b0;
        mRise[c]    = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit seen;
        seen = seenHist[c][0];
        mRise[c] = 1'b0;
        if (tick) begin
          if (seen != mLevel[c]) begin
            runLen[c]++;
            if (runLen[c] == N) begin
              mLevel[c] = seen;
              mRise[c]  = seen;
              runLen[c] = 0;
            end
          end else begin
            runLen[c] = 0;
          end
        end
        void'(seenHist[c].pop_front());
        seenHist[c].push_back(c == 0 ? rawA : rawB);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rawA = 1'b1; rawB = 1'b1; tick = 1'b1;
    step(); step();
    reset_n = 1'b1;
    repeat (8) step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({A, B, riseA, riseB} !== 4'b0000)
      $display("FAIL reset_async: got %b want 0000", {A, B, riseA, riseB});
    else passed++;
    step();
    reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if ({A, B, riseA, riseB} !== {e >= 5, e >= 5, e == 5, e == 5})
        $display("FAIL reset_release e%0d: got %b want %b", e,
                 {A, B, riseA, riseB}, {e >= 5, e >= 5, e == 5, e == 5});
      else passed++;
    end
  endtask

  task automatic test_clean_step();
    rawA = 1'b0; rawB = 1'b0;
    repeat (10) step();
    rawA = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if ({A, riseA} !== {e >= 5, e == 5})
        $display("FAIL clean_rise e%0d: got %b want %b", e, {A, riseA}, {e >= 5, e == 5});
      else passed++;
    end
    rawA = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if ({A, riseA} !== {e < 5, 1'b0})
        $display("FAIL clean_fall e%0d: got %b want %b", e, {A, riseA}, {e < 5, 1'b0});
      else passed++;
    end
  endtask

  task automatic test_glitch();
    rawA = 1'b1;
    for (int e = 0; e < 14; e++) begin
      if (e == 3) rawA = 1'b0;
      step();
      checks++;
      if ({A, riseA} !== 2'b00)
        $display("FAIL glitch e%0d: got %b want 00", e, {A, riseA});
      else passed++;
    end
  endtask

  task automatic test_sparse_tick();
    int ticksSeen;
    int riseEdge;
    ticksSeen = 0;
    riseEdge  = -1;
    rawB = 1'b1;
    for (int e = 0; e < 22; e++) begin
      tick = (e % 4 == 0);
      if (tick && e >= 2) begin
        ticksSeen++;
        if (ticksSeen == N) riseEdge = e;
      end
      step();
      checks++;
      if ({B, riseB} !== {riseEdge >= 0, riseEdge == e})
        $display("FAIL sparse_tick e%0d: got %b want %b", e, {B, riseB},
                 {riseEdge >= 0, riseEdge == e});
      else passed++;
    end
    tick = 1'b1;
  endtask

  task automatic test_reset_mid();
    rawA = 1'b1;
    for (int e = 0; e < 4; e++) step();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({A, B} !== 2'b00)
      $display("FAIL reset_mid_async: got %b want 00", {A, B});
    else passed++;
    step();
    reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if ({A, riseA} !== {e >= 5, e == 5})
        $display("FAIL reset_mid e%0d: got %b want %b", e, {A, riseA}, {e >= 5, e == 5});
      else passed++;
    end
  endtask

  task automatic test_independence();
    rawA = 1'b0; rawB = 1'b0;
    repeat (8) step();
    rawA = 1'b1; rawB = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if ({A, B, riseA, riseB} !== {e >= 5, e >= 5, e == 5, e == 5})
        $display("FAIL indep_step e%0d: got %b want %b", e,
                 {A, B, riseA, riseB}, {e >= 5, e >= 5, e == 5, e == 5});
      else passed++;
    end
    rawB = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (e == 2) rawB = 1'b1;
      step();
      checks++;
      if ({A, B, riseA, riseB} !== 4'b1100)
        $display("FAIL indep_glitchB e%0d: got %b want 1100", e, {A, B, riseA, riseB});
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) rawA = ~rawA;
      if ($urandom_range(0, 5) == 0) rawB = ~rawB;
      tick = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if ({A, B, riseA, riseB} !== {mLevel[0], mLevel[1], mRise[0], mRise[1]})
        $display("FAIL random c%0d: got %b want %b", i, {A, B, riseA, riseB},
                 {mLevel[0], mLevel[1], mRise[0], mRise[1]});
      else passed++;
    end
    tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_sparse_tick();
    test_reset_mid();
    test_independence();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
